// File: rtl/digit_chain_counter.sv
// digit_chain_counter
// Cascaded chain of NUM_DIGITS modulo-(DIGIT_MAX+1) digit counters with
// up/down counting, synchronous parallel load, registered per-digit wrap
// pulses (digit_trig) and a registered whole-chain wrap pulse (trig).
//
// Optional build macro: COUNTER_SATURATE_EN
//   defined   -> the chain holds at its full terminal state (all-DIGIT_MAX
//                counting up, all-zero counting down) instead of wrapping;
//                trig pulses on every enabled cycle while held.
//   undefined -> the chain wraps (default).
module digit_chain_counter #(
    parameter int DIGIT_WIDTH = 4,
    parameter int DIGIT_MAX   = 9,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              up,
    input  logic                              load,
    input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] load_val,
    output logic [NUM_DIGITS*DIGIT_WIDTH-1:0] count,
    output logic [NUM_DIGITS-1:0]             digit_trig,
    output logic                              trig,
    output logic                              zero
);

    localparam int CW = NUM_DIGITS * DIGIT_WIDTH;
    localparam logic [DIGIT_WIDTH-1:0] MAX_D = DIGIT_WIDTH'(DIGIT_MAX);

    // A digit is terminal when its next step in the current direction wraps.
    // Values above DIGIT_MAX count as terminal going up, so a loaded
    // out-of-range digit recovers to 0 on its next up step.
    function automatic logic is_terminal(input logic [DIGIT_WIDTH-1:0] d,
                                         input logic                   dir);
        if (dir) return (d >= MAX_D);
        else     return (d == '0);
    endfunction

    // Value a digit takes when it steps in the given direction.
    function automatic logic [DIGIT_WIDTH-1:0] step_digit(
        input logic [DIGIT_WIDTH-1:0] d,
        input logic                   dir
    );
        if (dir) begin
            if (d >= MAX_D) return '0;
            else            return d + 1'b1;
        end else begin
            if (d == '0)        return MAX_D;
            else if (d > MAX_D) return MAX_D;
            else                return d - 1'b1;
        end
    endfunction

    logic [NUM_DIGITS-1:0] terminal;    // digit i would wrap on its next step
    logic [NUM_DIGITS-1:0] step;        // digit i steps this cycle
    logic                  all_term;    // every digit terminal
    logic [CW-1:0]         next_count;  // count after an enabled step
    logic [NUM_DIGITS-1:0] next_dtrig;  // per-digit wrap pulses for next cycle
    logic                  next_trig;   // whole-chain wrap pulse for next cycle

    // Ripple the step enable up the chain and compute each digit's next value.
    always_comb begin : chain_decode
        logic lower_term;
        // NOTE: every always_comb output gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        terminal   = '0;
        step       = '0;
        next_count = count;
        lower_term = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            terminal[i] = is_terminal(count[i*DIGIT_WIDTH +: DIGIT_WIDTH], up);
            step[i]     = en & lower_term;
            if (step[i]) begin
                next_count[i*DIGIT_WIDTH +: DIGIT_WIDTH] =
                    step_digit(count[i*DIGIT_WIDTH +: DIGIT_WIDTH], up);
            end
            lower_term = lower_term & terminal[i];
        end
        all_term = lower_term;
    end

    // Resolve the wrap pulses, and in saturating builds hold the full chain.
    always_comb begin
        next_dtrig = step & terminal;
        next_trig  = en & all_term;
`ifdef COUNTER_SATURATE_EN
        if (en && all_term) begin
            next_count = count;
            next_dtrig = '0;
        end
`endif
    end

    // State register: reset beats load, load beats counting.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            count      <= '0;
            digit_trig <= '0;
            trig       <= 1'b0;
        end else if (load) begin
            count      <= load_val;
            digit_trig <= '0;
            trig       <= 1'b0;
        end else begin
            count      <= next_count;
            digit_trig <= next_dtrig;
            trig       <= next_trig;
        end
    end

    // All-digits-zero decode, straight off the count register.
    assign zero = (count == '0);

endmodule

// File: tb/tb_digit_chain_counter.sv
// tb_digit_chain_counter
// Table-driven directed vectors for the default 4-digit decimal chain, plus
// hand-written multi-cycle sequences and a single-digit instance.
module tb_digit_chain_counter;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic [3:0]  digit_trig;
    logic        trig, zero;

    logic        rst1, en1, up1, load1;
    logic [3:0]  load_val1;
    logic [3:0]  count1;
    logic [0:0]  digit_trig1;
    logic        trig1, zero1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    digit_chain_counter #(.DIGIT_WIDTH(4), .DIGIT_MAX(9), .NUM_DIGITS(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .digit_trig(digit_trig),
        .trig(trig), .zero(zero)
    );

    digit_chain_counter #(.DIGIT_WIDTH(4), .DIGIT_MAX(9), .NUM_DIGITS(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .up(up1), .load(load1),
        .load_val(load_val1), .count(count1), .digit_trig(digit_trig1),
        .trig(trig1), .zero(zero1)
    );

    typedef struct {
        logic        rst;
        logic        load;
        logic        en;
        logic        up;
        logic [15:0] load_val;
        logic [15:0] exp_count;
        logic [3:0]  exp_dtrig;
        logic        exp_trig;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic add(input logic r, input logic l, input logic e, input logic u,
                       input logic [15:0] lv, input logic [15:0] ec,
                       input logic [3:0] edt, input logic et, input logic ez);
        vec_t v;
        v.rst = r; v.load = l; v.en = e; v.up = u; v.load_val = lv;
        v.exp_count = ec; v.exp_dtrig = edt; v.exp_trig = et; v.exp_zero = ez;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int dt1_pulses, dt2_pulses, dt3_pulses, trig_pulses;

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        rst1 = 1'b1; en1 = 1'b0; up1 = 1'b1; load1 = 1'b0; load_val1 = '0;

        // ---------------- vector table ----------------
        //   rst load en up  load_val  count    dtrig    trig zero
        add(1, 0, 0, 1, 16'h0000, 16'h0000, 4'b0000, 0, 1);  // reset state
        // count up 0..9 then carry into digit 1
        for (int k = 1; k <= 9; k++)
            add(0, 0, 1, 1, 16'h0000, 16'(k), 4'b0000, 0, 0);
        add(0, 0, 1, 1, 16'h0000, 16'h0010, 4'b0001, 0, 0);
        // ripple carry through three digits
        add(0, 1, 0, 1, 16'h0999, 16'h0999, 4'b0000, 0, 0);
        add(0, 0, 1, 1, 16'h0000, 16'h1000, 4'b0111, 0, 0);
        // whole-chain wrap up
        add(0, 1, 0, 1, 16'h9999, 16'h9999, 4'b0000, 0, 0);
`ifdef COUNTER_SATURATE_EN
        add(0, 0, 1, 1, 16'h0000, 16'h9999, 4'b0000, 1, 0);
`else
        add(0, 0, 1, 1, 16'h0000, 16'h0000, 4'b1111, 1, 1);
`endif
        // whole-chain wrap down from reset, then one plain down step
        add(1, 0, 0, 1, 16'h0000, 16'h0000, 4'b0000, 0, 1);
`ifdef COUNTER_SATURATE_EN
        add(0, 0, 1, 0, 16'h0000, 16'h0000, 4'b0000, 1, 1);
        add(0, 0, 1, 0, 16'h0000, 16'h0000, 4'b0000, 1, 1);
`else
        add(0, 0, 1, 0, 16'h0000, 16'h9999, 4'b1111, 1, 0);
        add(0, 0, 1, 0, 16'h0000, 16'h9998, 4'b0000, 0, 0);
`endif
        // out-of-range digit counting down clamps to DIGIT_MAX
        add(0, 1, 0, 0, 16'h00F0, 16'h00F0, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 16'h0000, 16'h0099, 4'b0001, 0, 0);
        // direction changes take effect on the very next step
        add(0, 0, 1, 0, 16'h0000, 16'h0098, 4'b0000, 0, 0);
        add(0, 0, 1, 1, 16'h0000, 16'h0099, 4'b0000, 0, 0);
        add(0, 0, 1, 1, 16'h0000, 16'h0100, 4'b0011, 0, 0);
        add(0, 0, 1, 0, 16'h0000, 16'h0099, 4'b0011, 0, 0);
        // en low holds
        add(0, 0, 0, 1, 16'h0000, 16'h0099, 4'b0000, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 16'h0099, 4'b0000, 0, 0);
        // load beats en; no pulses on a load cycle
        add(0, 1, 1, 1, 16'h1234, 16'h1234, 4'b0000, 0, 0);
        // out-of-range load kept verbatim, then each digit wraps going up
        add(0, 1, 0, 1, 16'hABCD, 16'hABCD, 4'b0000, 0, 0);
`ifdef COUNTER_SATURATE_EN
        add(0, 0, 1, 1, 16'h0000, 16'hABCD, 4'b0000, 1, 0);
`else
        add(0, 0, 1, 1, 16'h0000, 16'h0000, 4'b1111, 1, 1);
`endif
        add(0, 1, 0, 1, 16'hABCD, 16'hABCD, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 16'h0000, 16'hABC9, 4'b0000, 0, 0);
        // reset beats a wrapping enabled step and suppresses trig
        add(0, 1, 0, 1, 16'h9999, 16'h9999, 4'b0000, 0, 0);
        add(1, 1, 1, 1, 16'h5555, 16'h0000, 4'b0000, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; load = vecs[i].load; en = vecs[i].en;
            up = vecs[i].up; load_val = vecs[i].load_val;
            tick();
            check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("v%0d digit_trig", i), 32'(digit_trig), 32'(vecs[i].exp_dtrig));
            check($sformatf("v%0d trig", i), 32'(trig), 32'(vecs[i].exp_trig));
            check($sformatf("v%0d zero", i), 32'(zero), 32'(vecs[i].exp_zero));
        end

        // ---------------- 1000 up steps from reset ----------------
        rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1;
        tick();
        rst = 1'b0; en = 1'b1;
        dt1_pulses = 0; dt2_pulses = 0; dt3_pulses = 0; trig_pulses = 0;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            if (digit_trig[1]) dt1_pulses++;
            if (digit_trig[2]) dt2_pulses++;
            if (digit_trig[3]) dt3_pulses++;
            if (trig) trig_pulses++;
            if (k == 1000) check("long digit_trig2 at 1000", 32'(digit_trig[2]), 32'd1);
        end
        check("long count", 32'(count), 32'h1000);
        check("long dt1 pulses", 32'(dt1_pulses), 32'd10);
        check("long dt2 pulses", 32'(dt2_pulses), 32'd1);
        check("long dt3 pulses", 32'(dt3_pulses), 32'd0);
        check("long trig pulses", 32'(trig_pulses), 32'd0);
        // one down step borrows through three digits
        up = 1'b0;
        tick();
        check("borrow count", 32'(count), 32'h0999);
        check("borrow digit_trig", 32'(digit_trig), 32'b0111);
        check("borrow trig", 32'(trig), 32'd0);
        en = 1'b0;

        // ---------------- single-digit chain ----------------
        tick();
        rst1 = 1'b0; en1 = 1'b1; up1 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("n1 count step%0d", k), 32'(count1), 32'(k));
            check($sformatf("n1 trig step%0d", k), 32'(trig1), 32'd0);
        end
        tick();
`ifdef COUNTER_SATURATE_EN
        check("n1 held count", 32'(count1), 32'd9);
        check("n1 held digit_trig", 32'(digit_trig1), 32'd0);
`else
        check("n1 wrap count", 32'(count1), 32'd0);
        check("n1 wrap digit_trig", 32'(digit_trig1), 32'd1);
`endif
        check("n1 wrap trig", 32'(trig1), 32'd1);
        en1 = 1'b0;
        tick();
        check("n1 idle trig", 32'(trig1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digit_chain_counter.md
Name: digit_chain_counter

Overview:
Parametrised chain of NUM_DIGITS cascaded modulo-(DIGIT_MAX+1) digit counters. Digit 0 steps on each enabled cycle, and each higher digit steps only when every lower digit is at its terminal value. The chain supports up/down counting, synchronous parallel load, registered per-digit rollover pulses and a whole-chain wrap pulse. It serves as the timebase/event counter for display, timer and performance-count logic in the SoC peripherals.

Parameters:
DIGIT_WIDTH, 4, bits per digit; must satisfy 2^DIGIT_WIDTH > DIGIT_MAX
DIGIT_MAX, 9, terminal value of each digit (digit counts 0..DIGIT_MAX)
NUM_DIGITS, 4, number of cascaded digits, >= 1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  count enable; one step per cycle when high
up  input  1  direction: 1 = count up, 0 = count down; sampled each cycle
load  input  1  synchronous parallel load strobe
load_val  input  NUM_DIGITS*DIGIT_WIDTH  load value; digit i at bits [i*DIGIT_WIDTH +: DIGIT_WIDTH]
count  output  NUM_DIGITS*DIGIT_WIDTH  registered digit values, same packing as load_val
digit_trig  output  NUM_DIGITS  registered one-cycle pulse per digit on that digit's wrap
trig  output  1  registered one-cycle pulse on whole-chain wrap
zero  output  1  combinational decode: 1 when all digits are 0

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset has priority over everything else. Values after reset: count = 0, digit_trig = 0, trig = 0, zero = 1.
- Priority order: rst > load > en.
- load=1: count <= load_val on the next edge, regardless of en or up. digit_trig and trig are 0 on that cycle. Load values above DIGIT_MAX are accepted unchanged.
- Terminal value per digit: when up=1, digit >= DIGIT_MAX; when up=0, digit == 0.
- Step enable for digit i: en & !load & !rst & (every digit j < i is terminal). Digit 0's step enable is just en (gated by !load and !rst).
- Up step: if digit >= DIGIT_MAX, digit <= 0 (wrap); otherwise digit <= digit+1.
- Down step: if digit == 0, digit <= DIGIT_MAX (wrap); if digit > DIGIT_MAX, digit <= DIGIT_MAX; otherwise digit <= digit-1.
- digit_trig[i] <= 1 exactly when digit i steps and is terminal on that cycle, i.e. it wraps. It is high for one cycle, coincident with the wrapped count value. In all other cycles it is 0.
- trig <= 1 when en is high and all digits are terminal, i.e. the whole chain wraps. It is high for one cycle and equals digit_trig[NUM_DIGITS-1] in wrapping mode.
- en=0 with load=0: count holds and all pulses are 0.
- Changing up between cycles takes effect immediately on the next step. There is no pipeline and the latency is 1 cycle.
- A reset asserted mid-count clears everything on the next edge. Any pulse that would have fired in that cycle is suppressed.
- NUM_DIGITS=1 degenerates to a single modulo-(DIGIT_MAX+1) counter with trig == digit_trig[0].

Optional Feature:
Macro COUNTER_SATURATE_EN.
- Defined: the chain saturates instead of wrapping. In up mode, when all digits are terminal and en=1, count holds at all-DIGIT_MAX. In down mode it holds at all-zero. trig pulses on every such enabled cycle while held. digit_trig is 0 when the chain is held. Partial-digit wraps below the full terminal state behave as normal.
- Undefined: wrapping behaviour as specified above. No saturation logic is present.

Test Plan:
1. Reset then en=1, up=1 for 10 cycles: count goes 0x0000..0x0009 then 0x0010. digit_trig[0]=1 in the cycle count=0x0010, and digit_trig[1]=0.
2. load 0x0999 then en=1, up=1 for 1 cycle: count=0x1000 and digit_trig[2:0]=3'b111 in the same cycle, with trig=0.
3. load 0x9999 then en=1, up=1: count=0x0000, trig=1, digit_trig=4'b1111, zero=1. With COUNTER_SATURATE_EN, count stays 0x9999 with trig=1 and digit_trig=0.
4. After reset, en=1, up=0: count=0x9999 and trig=1. Next cycle count=0x9998 and trig=0.
5. load 0x00F0 then up=0, en=1: digit0 wraps to 9, and digit1 (0xF > DIGIT_MAX) becomes 9, giving count=0x0099.
6. en=1 with load=1 and load_val=0x1234 in the same cycle: count=0x1234 and no pulses. Then rst=1 in a cycle where count=0x9999 with en=1: count=0 and trig=0.
